router_fifo: RTL and testbench

ROUTER_FIFO -- requirements
Module: router_fifo

---
 rtl/router_fifo_if.sv | 25 ++
 rtl/router_fifo.sv | 87 ++++++++
 tb/tb_router_fifo.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/router_fifo_if.sv
// Handshake and data bundle between a packet router's write/read control and its byte FIFO.
// The master drives requests and write data; the slave (the FIFO) returns status and read data.
interface router_fifo_if #(
  parameter int WIDTH = 8
);
  logic             soft_reset;
  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [WIDTH-1:0] data_in;
  logic [WIDTH-1:0] data_out;
  logic             full;
  logic             empty;
  logic             pkt_busy;

  modport master (
    output soft_reset, write_enb, read_enb, lfd_state, data_in,
    input  data_out, full, empty, pkt_busy
  );

  modport slave (
    input  soft_reset, write_enb, read_enb, lfd_state, data_in,
    output data_out, full, empty, pkt_busy
  );
endinterface

// File: rtl/router_fifo.sv
// Byte FIFO for a packet router: each entry carries a header flag, and the read side
// tracks how many bytes remain in the packet being drained.
module router_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic          clock,
  input  logic          resetn,
  router_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [6:0]       pkt_count_q, pkt_count_d;
  logic [WIDTH-1:0] data_out_q, data_out_d;
  logic [WIDTH:0]   mem [DEPTH];
  logic [WIDTH:0]   rd_word;
  logic             full, empty, wr_acc, rd_acc;

  // A header read restarts the count at payload length plus the parity byte;
  // other reads count down and stop at zero.
  function automatic logic [6:0] next_pkt_count(input logic       hdr,
                                                input logic [5:0] len,
                                                input logic [6:0] cnt);
    if (hdr)
      return {1'b0, len} + 7'd1;
    else if (cnt != 7'd0)
      return cnt - 7'd1;
    else
      return cnt;
  endfunction

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign wr_acc  = bus.write_enb && !full && !bus.soft_reset;
  assign rd_acc  = bus.read_enb && !empty && !bus.soft_reset;
  assign rd_word = mem[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    pkt_count_d = pkt_count_q;
    data_out_d  = data_out_q;
    if (bus.soft_reset) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      pkt_count_d = '0;
      data_out_d  = '0;
    end else begin
      if (wr_acc)
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (rd_acc) begin
        rd_ptr_d    = rd_ptr_q + PTR_ONE;
        data_out_d  = rd_word[WIDTH-1:0];
        pkt_count_d = next_pkt_count(rd_word[WIDTH], rd_word[7:2], pkt_count_q);
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pkt_count_q <= '0;
      data_out_q  <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pkt_count_q <= pkt_count_d;
      data_out_q  <= data_out_d;
    end
  end

  // Storage is never reset; stale entries are unreachable because the pointers are.
  always_ff @(posedge clock) begin
    if (wr_acc)
      mem[wr_ptr_q[AW-1:0]] <= {bus.lfd_state, bus.data_in};
  end

  assign bus.data_out = data_out_q;
  assign bus.full     = full;
  assign bus.empty    = empty;
  assign bus.pkt_busy = (pkt_count_q != 7'd0);
endmodule

// File: tb/tb_router_fifo.sv
// Directed bench for router_fifo: packet drain, full/empty boundaries, simultaneous
// access, soft and hard reset, and pointer wrap.
module tb_router_fifo;
  logic clock;
  logic resetn;
  int   n_cmp;
  int   n_bad;

  router_fifo_if #(.WIDTH(8)) bus ();

  router_fifo #(.DEPTH(16), .WIDTH(8)) dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [7:0] b, input logic hdr);
    bus.write_enb = 1'b1;
    bus.lfd_state = hdr;
    bus.data_in   = b;
    step();
    bus.write_enb = 1'b0;
    bus.lfd_state = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [7:0] exp);
    bus.read_enb = 1'b1;
    step();
    bus.read_enb = 1'b0;
    chk(tag, bus.data_out, exp);
  endtask

  initial begin
    n_cmp          = 0;
    n_bad          = 0;
    resetn         = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b0;
    bus.read_enb   = 1'b0;
    bus.lfd_state  = 1'b0;
    bus.data_in    = 8'h00;
    #12;
    chk("rst_empty", bus.empty, 1);
    chk("rst_full", bus.full, 0);
    chk("rst_busy", bus.pkt_busy, 0);
    chk("rst_dout", bus.data_out, 8'h00);
    resetn = 1'b1;
    step();

    // Packet: header 0x0C -> length 3 + parity = 4 bytes follow
    wr(8'h0C, 1'b1);
    chk("pkt_not_empty", bus.empty, 0);
    wr(8'h11, 1'b0);
    wr(8'h22, 1'b0);
    wr(8'h33, 1'b0);
    wr(8'h3C, 1'b0);
    rd_chk("pkt_hdr", 8'h0C);
    chk("pkt_busy_hdr", bus.pkt_busy, 1);
    rd_chk("pkt_b1", 8'h11);
    chk("pkt_busy_b1", bus.pkt_busy, 1);
    rd_chk("pkt_b2", 8'h22);
    rd_chk("pkt_b3", 8'h33);
    chk("pkt_busy_b3", bus.pkt_busy, 1);
    rd_chk("pkt_par", 8'h3C);
    chk("pkt_busy_par", bus.pkt_busy, 0);
    chk("pkt_empty", bus.empty, 1);
    step();
    chk("hold_idle", bus.data_out, 8'h3C);
    rd_chk("rd_when_empty", 8'h3C);
    chk("rd_empty_empty", bus.empty, 1);

    // Fill to full, overflow write ignored, drain in order
    for (int i = 0; i < 16; i++) begin
      chk("fill_not_full", bus.full, 0);
      wr(8'(i), 1'b0);
    end
    chk("full_set", bus.full, 1);
    chk("full_not_empty", bus.empty, 0);
    wr(8'hFF, 1'b0);
    chk("full_after_ovf", bus.full, 1);
    for (int i = 0; i < 16; i++)
      rd_chk($sformatf("drain_%0d", i), 8'(i));
    chk("drain_empty", bus.empty, 1);
    chk("drain_busy", bus.pkt_busy, 0);

    // Simultaneous read/write at full: read wins, write dropped
    for (int i = 0; i < 16; i++)
      wr(8'(i), 1'b0);
    chk("full2_set", bus.full, 1);
    bus.write_enb = 1'b1;
    bus.data_in   = 8'hEE;
    bus.read_enb  = 1'b1;
    step();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    chk("sim_full_dout", bus.data_out, 8'h00);
    chk("sim_full_full", bus.full, 0);
    for (int i = 1; i < 16; i++)
      rd_chk($sformatf("sim_drain_%0d", i), 8'(i));
    chk("sim_drain_empty", bus.empty, 1);

    // Simultaneous read/write at empty: write wins, read dropped
    bus.write_enb = 1'b1;
    bus.data_in   = 8'h5A;
    bus.read_enb  = 1'b1;
    step();
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    chk("sim_empty_dout", bus.data_out, 8'h0F);
    chk("sim_empty_empty", bus.empty, 0);
    rd_chk("sim_empty_rd", 8'h5A);
    chk("sim_empty_after", bus.empty, 1);

    // Soft reset mid-packet overrides a simultaneous read
    wr(8'h0C, 1'b1);
    wr(8'h11, 1'b0);
    rd_chk("sr_hdr", 8'h0C);
    chk("sr_busy_before", bus.pkt_busy, 1);
    bus.soft_reset = 1'b1;
    bus.read_enb   = 1'b1;
    step();
    bus.soft_reset = 1'b0;
    bus.read_enb   = 1'b0;
    chk("sr_empty", bus.empty, 1);
    chk("sr_busy", bus.pkt_busy, 0);
    chk("sr_dout", bus.data_out, 8'h00);

    // Wrap: advance pointers by 10, then push 12 across the index wrap
    for (int i = 0; i < 10; i++) begin
      wr(8'(8'h40 + i), 1'b0);
      rd_chk($sformatf("pre_%0d", i), 8'(8'h40 + i));
    end
    for (int i = 0; i < 12; i++)
      wr(8'(8'hA0 + i), 1'b0);
    chk("wrap_not_full", bus.full, 0);
    for (int i = 0; i < 12; i++)
      rd_chk($sformatf("wrap_%0d", i), 8'(8'hA0 + i));
    chk("wrap_empty", bus.empty, 1);

    // Asynchronous reset mid-traffic, observed before any clock edge
    wr(8'h10, 1'b1);
    wr(8'h77, 1'b0);
    rd_chk("ar_hdr", 8'h10);
    chk("ar_busy_before", bus.pkt_busy, 1);
    #2;
    resetn = 1'b0;
    #1;
    chk("ar_empty", bus.empty, 1);
    chk("ar_full", bus.full, 0);
    chk("ar_busy", bus.pkt_busy, 0);
    chk("ar_dout", bus.data_out, 8'h00);
    resetn = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
